wave_display: RTL and testbench

- Pixel-domain consumer of the DSO sample RAM.
- Scans the LCD/HDMI pixel stream, generates the sample-RAM read address for each wave-window column, and turns the returned 8-bit samples into a continuous trace bitmap.
- Also generates a graticule bitmap and a trigger-level marker bitmap.
- Signals capture/display hand-over to the sample store through ram_rd_over.

---
 rtl/dso_disp_pkg.sv | 32 +++
 rtl/dso_grid_gen.sv | 56 +++++
 rtl/wave_display.sv | 142 ++++++++++++++
 tb/tb_wave_display.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dso_disp_pkg.sv
// Shared constants for the DSO wave display: window geometry, grid pitch,
// sample coding and FSM state encodings.
package dso_disp_pkg;

    localparam int unsigned H_BITS    = 11;
    localparam int unsigned WAVE_W    = 500;
    localparam int unsigned WAVE_X0   = 100;
    localparam int unsigned WAVE_Y0   = 100;
    localparam int unsigned GRID_STEP = 50;

    // Window edges in pixel coordinates (height fixed at 256 rows)
    localparam logic [H_BITS-1:0] WIN_X_FIRST = H_BITS'(WAVE_X0);
    localparam logic [H_BITS-1:0] WIN_X_LAST  = H_BITS'(WAVE_X0 + WAVE_W - 1);
    localparam logic [H_BITS-1:0] WIN_Y_FIRST = H_BITS'(WAVE_Y0);
    localparam logic [H_BITS-1:0] WIN_Y_LAST  = H_BITS'(WAVE_Y0 + 255);

    // Column offset subtracted at address width
    localparam logic [8:0] ADDR_X0 = 9'(WAVE_X0);

    // Sample code meaning "no sample / out of range"
    localparam logic [7:0] NO_SAMPLE = 8'hFF;

    // Grid wrap counters
    localparam int unsigned           CNT_BITS  = $clog2(GRID_STEP);
    localparam logic [CNT_BITS-1:0]   STEP_LAST = CNT_BITS'(GRID_STEP - 1);

    // FSM states
    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

endpackage

// File: rtl/dso_grid_gen.sv
// Graticule generator: per-axis wrap counters replace (coord - origin) mod
// GRID_STEP, plus window border and the dotted pattern.
module dso_grid_gen
    import dso_disp_pkg::*;
(
    input  logic              rstn,
    input  logic              ram_rd_clk,
    input  logic              win_i,
    input  logic [H_BITS-1:0] x_i,
    input  logic [H_BITS-1:0] y_i,
    output logic              grid_o
);

    logic [CNT_BITS-1:0] col_cnt_q, col_cnt_d;
    logic [CNT_BITS-1:0] row_cnt_q, row_cnt_d;
    logic [CNT_BITS-1:0] xmod, ymod;
    logic                x_first, x_last, y_first, y_last;
    logic                border;
    logic [1:0]          dot_sum;

    // Counters restart at the window origin; row counter steps at each row's last column
    always_comb begin
        x_first = (x_i == WIN_X_FIRST);
        x_last  = (x_i == WIN_X_LAST);
        y_first = (y_i == WIN_Y_FIRST);
        y_last  = (y_i == WIN_Y_LAST);
        xmod    = x_first ? '0 : col_cnt_q;
        ymod    = y_first ? '0 : row_cnt_q;

        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (win_i) begin
            col_cnt_d = (xmod == STEP_LAST) ? '0 : xmod + 1'b1;
            if (x_last) begin
                row_cnt_d = (ymod == STEP_LAST) ? '0 : ymod + 1'b1;
            end
        end

        border  = x_first || x_last || y_first || y_last;
        // bit 1 of (x + y) only depends on the two low bits of each operand
        dot_sum = x_i[1:0] + y_i[1:0];
        grid_o  = win_i && ((xmod == '0) || (ymod == '0) || border) && !dot_sum[1];
    end

    // Wrap counter state
    always_ff @(posedge ram_rd_clk or negedge rstn) begin
        if (!rstn) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
        end
    end

endmodule

// File: rtl/wave_display.sv
// Wave window renderer: issues sample-RAM reads per column, turns returned
// samples into a continuous trace, overlays graticule and trigger marker,
// and flags frame completion to the capture side through ram_rd_over.
module wave_display
    import dso_disp_pkg::*;
(
    input  logic              rstn,
    input  logic              ram_rd_clk,
    input  logic              frame_start,
    input  logic [H_BITS-1:0] pixel_x,
    input  logic [H_BITS-1:0] pixel_y,
    input  logic              pixel_de,
    input  logic [7:0]        trig_level,
    input  logic [7:0]        wave_rd_data,
    output logic [8:0]        wave_rd_addr,
    output logic              ram_rd_en,
    output logic              ram_rd_over,
    output logic              wave_pix,
    output logic              grid_pix,
    output logic              trig_pix,
    output logic              de_o
);

    logic [1:0]        state_q, state_d;
    logic              in_win, last_pix;

    // Stage 1
    logic [H_BITS-1:0] x1_q, x1_d, y1_q, y1_d;
    logic              win1_q, win1_d, de1_q, de1_d, draw1_q, draw1_d;

    // Previous column of the trace
    logic [H_BITS-1:0] yprev_q, yprev_d;
    logic              vprev_q, vprev_d;

    // Stage 2 outputs
    logic              wave_q, wave_d, grid_q, grid_d, trig_q, trig_d, de2_q, de2_d;

    logic [H_BITS-1:0] ycur, ylo, yhi, trig_y;
    logic              vcur, pv_eff, on_trace, grid_hit;

    // Stage 0: window decode and RAM read request, combinational so data lands next cycle
    always_comb begin
        in_win = pixel_de
              && (pixel_x >= WIN_X_FIRST) && (pixel_x <= WIN_X_LAST)
              && (pixel_y >= WIN_Y_FIRST) && (pixel_y <= WIN_Y_LAST);
        last_pix     = in_win && (pixel_x == WIN_X_LAST) && (pixel_y == WIN_Y_LAST);
        wave_rd_addr = in_win ? (pixel_x[8:0] - ADDR_X0) : 9'd0;
        ram_rd_en    = in_win && (state_q == ST_DRAW);
    end

    // Frame FSM; a frame_start during DRAW restarts the frame without passing OVER
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: if (frame_start) state_d = ST_DRAW;
            ST_DRAW: begin
                if (frame_start) begin
                    state_d = ST_DRAW;
                end else if (last_pix) begin
                    state_d = ST_OVER;
                end
            end
            ST_OVER: if (frame_start) state_d = ST_DRAW;
            default: state_d = ST_WAIT;
        endcase
    end

    assign ram_rd_over = (state_q == ST_OVER);

    dso_grid_gen u_grid (
        .rstn       (rstn),
        .ram_rd_clk (ram_rd_clk),
        .win_i      (win1_q),
        .x_i        (x1_q),
        .y_i        (y1_q),
        .grid_o     (grid_hit)
    );

    // Stage 1 capture and stage 2 pixel decisions from the returned sample
    always_comb begin
        x1_d    = pixel_x;
        y1_d    = pixel_y;
        win1_d  = in_win;
        de1_d   = pixel_de;
        draw1_d = ram_rd_en;

        ycur   = WIN_Y_LAST - {{(H_BITS-8){1'b0}}, wave_rd_data};
        vcur   = win1_q && (wave_rd_data != NO_SAMPLE);
        // First column of a row never joins to the previous row's last column
        pv_eff = vprev_q && (x1_q != WIN_X_FIRST);
        ylo    = (ycur < yprev_q) ? ycur : yprev_q;
        yhi    = (ycur < yprev_q) ? yprev_q : ycur;
        on_trace = pv_eff ? ((y1_q >= ylo) && (y1_q <= yhi)) : (y1_q == ycur);

        yprev_d = win1_q ? ycur : yprev_q;
        vprev_d = win1_q ? vcur : vprev_q;

        trig_y = WIN_Y_LAST - {{(H_BITS-8){1'b0}}, trig_level};

        wave_d = draw1_q && vcur && on_trace;
        grid_d = grid_hit;
        trig_d = win1_q && (y1_q == trig_y) && !x1_q[2];
        de2_d  = de1_q;
    end

    // Pipeline and FSM state
    always_ff @(posedge ram_rd_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_WAIT;
            x1_q    <= '0;
            y1_q    <= '0;
            win1_q  <= 1'b0;
            de1_q   <= 1'b0;
            draw1_q <= 1'b0;
            yprev_q <= '0;
            vprev_q <= 1'b0;
            wave_q  <= 1'b0;
            grid_q  <= 1'b0;
            trig_q  <= 1'b0;
            de2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            win1_q  <= win1_d;
            de1_q   <= de1_d;
            draw1_q <= draw1_d;
            yprev_q <= yprev_d;
            vprev_q <= vprev_d;
            wave_q  <= wave_d;
            grid_q  <= grid_d;
            trig_q  <= trig_d;
            de2_q   <= de2_d;
        end
    end

    assign wave_pix = wave_q;
    assign grid_pix = grid_q;
    assign trig_pix = trig_q;
    assign de_o     = de2_q;

endmodule

// File: tb/tb_wave_display.sv
// Directed bench for wave_display: sample RAM model, expected pixels from the
// window/trace/grid/marker rules, two-cycle output pipeline in the bench.
module tb_wave_display;

    logic        rstn, ram_rd_clk, frame_start, pixel_de;
    logic [10:0] pixel_x, pixel_y;
    logic [7:0]  trig_level, wave_rd_data;
    logic [8:0]  wave_rd_addr;
    logic        ram_rd_en, ram_rd_over, wave_pix, grid_pix, trig_pix, de_o;

    int          total, bad;
    logic [7:0]  mem [0:511];
    bit          full_row [0:1023];

    // Expected model state
    int          m_state;          // 0 wait, 1 draw, 2 over
    bit          m_pv;
    int          m_py;
    bit          chk_grid;
    logic [3:0]  exp1, exp2;       // {wave, grid, trig, de}
    bit          g1, g2;
    int          px1, py1, px2, py2, msg_x, msg_y;

    wave_display dut (
        .rstn         (rstn),
        .ram_rd_clk   (ram_rd_clk),
        .frame_start  (frame_start),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_de     (pixel_de),
        .trig_level   (trig_level),
        .wave_rd_data (wave_rd_data),
        .wave_rd_addr (wave_rd_addr),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_over  (ram_rd_over),
        .wave_pix     (wave_pix),
        .grid_pix     (grid_pix),
        .trig_pix     (trig_pix),
        .de_o         (de_o)
    );

    initial ram_rd_clk = 1'b0;
    always #5 ram_rd_clk = ~ram_rd_clk;

    // Sample RAM: one-cycle read latency
    always @(posedge ram_rd_clk) wave_rd_data <= mem[wave_rd_addr];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s at px(%0d,%0d): observed=%0h expected=%0h",
                   tag, msg_x, msg_y, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge ram_rd_clk);
        rstn        = 1'b0;
        pixel_de    = 1'b0;
        frame_start = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        #1;
        msg_x = -1; msg_y = -1;
        check("rst_wave_pix", wave_pix, 0);
        check("rst_grid_pix", grid_pix, 0);
        check("rst_trig_pix", trig_pix, 0);
        check("rst_de_o", de_o, 0);
        check("rst_ram_rd_over", ram_rd_over, 0);
        check("rst_ram_rd_en", ram_rd_en, 0);
        check("rst_wave_rd_addr", wave_rd_addr, 0);
        m_state = 0; m_pv = 0; m_py = 0;
        exp1 = '0; exp2 = '0; g1 = 1'b1; g2 = 1'b1;
        @(negedge ram_rd_clk);
        @(negedge ram_rd_clk);
        rstn = 1'b1;
    endtask

    // One pixel clock: check outputs of the pixel driven two steps ago, then drive
    task automatic step(input int x, input int y, input bit de, input bit fs);
        int d, ycur, lo, hi;
        bit win, en, vcur, pv, onl, ew, eg, et;
        @(negedge ram_rd_clk);
        msg_x = px2; msg_y = py2;
        check("wave_pix", wave_pix, exp2[3]);
        if (g2) check("grid_pix", grid_pix, exp2[2]);
        check("trig_pix", trig_pix, exp2[1]);
        check("de_o", de_o, exp2[0]);
        check("ram_rd_over", ram_rd_over, (m_state == 2));

        pixel_x     = 11'(x);
        pixel_y     = 11'(y);
        pixel_de    = de;
        frame_start = fs;
        win = de && (x >= 100) && (x <= 599) && (y >= 100) && (y <= 355);
        en  = win && (m_state == 1);
        #1;
        msg_x = x; msg_y = y;
        check("wave_rd_addr", wave_rd_addr, win ? 16'(x - 100) : 16'd0);
        check("ram_rd_en", ram_rd_en, en);

        d    = win ? int'(mem[x - 100]) : 0;
        ycur = 355 - d;
        vcur = win && (d != 255);
        pv   = m_pv && (x != 100);
        lo   = (ycur < m_py) ? ycur : m_py;
        hi   = (ycur < m_py) ? m_py : ycur;
        onl  = pv ? ((y >= lo) && (y <= hi)) : (y == ycur);
        ew   = en && vcur && onl;
        if (win) begin
            m_pv = vcur;
            m_py = ycur;
        end
        eg = win && ((((x - 100) % 50) == 0) || (((y - 100) % 50) == 0) ||
                     (x == 100) || (x == 599) || (y == 100) || (y == 355))
                 && ((((x + y) >> 1) % 2) == 0);
        et = win && (y == 355 - int'(trig_level)) && (((x >> 2) % 2) == 0);

        exp2 = exp1; g2 = g1; px2 = px1; py2 = py1;
        exp1 = {ew, eg, et, de}; g1 = chk_grid; px1 = x; py1 = y;

        if (fs) m_state = 1;
        else if ((m_state == 1) && win && (x == 599) && (y == 355)) m_state = 2;
    endtask

    task automatic scan_rows(input int y0, input int y1);
        for (int y = y0; y <= y1; y++) begin
            if (full_row[y]) begin
                for (int x = 98; x <= 601; x++) step(x, y, 1'b1, 1'b0);
            end else begin
                step(99, y, 1'b1, 1'b0);
                for (int x = 100; x <= 103; x++) step(x, y, 1'b1, 1'b0);
                step(599, y, 1'b1, 1'b0);
                step(600, y, 1'b1, 1'b0);
            end
            step(0, 0, 1'b0, 1'b0);
        end
    endtask

    task automatic scan_frame();
        step(0, 0, 1'b0, 1'b1);
        step(0, 0, 1'b0, 1'b0);
        scan_rows(99, 356);
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0);
    endtask

    task automatic clear_rows();
        for (int i = 0; i < 1024; i++) full_row[i] = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        rstn = 1'b0; frame_start = 1'b0; pixel_de = 1'b0;
        pixel_x = '0; pixel_y = '0; trig_level = 8'd0;
        chk_grid = 1'b1; m_state = 0; m_pv = 0; m_py = 0;
        exp1 = '0; exp2 = '0; g1 = 1'b1; g2 = 1'b1;
        px1 = 0; py1 = 0; px2 = 0; py2 = 0; msg_x = 0; msg_y = 0;
        for (int i = 0; i < 512; i++) mem[i] = 8'd128;
        clear_rows();

        do_reset();

        // WAIT: no read enable, no trace; grid counters not yet aligned
        chk_grid = 1'b0;
        for (int x = 150; x <= 153; x++) step(x, 227, 1'b1, 1'b0);
        step(0, 0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0);
        chk_grid = 1'b1;

        // Frame A: flat 128 trace on row 227, trigger 0 on bottom row
        full_row[150] = 1'b1; full_row[227] = 1'b1; full_row[355] = 1'b1;
        scan_frame();

        // Frame B: isolated samples 200/100 at indices 9/10, trigger 255 on top row
        clear_rows();
        for (int i = 0; i < 512; i++) mem[i] = 8'd255;
        mem[9] = 8'd200; mem[10] = 8'd100;
        trig_level = 8'd255;
        full_row[100] = 1'b1; full_row[154] = 1'b1; full_row[155] = 1'b1;
        full_row[200] = 1'b1; full_row[255] = 1'b1; full_row[256] = 1'b1;
        scan_frame();

        // Frame C: missing sample at index 20 breaks the trace
        clear_rows();
        for (int i = 0; i < 512; i++) mem[i] = 8'd128;
        mem[20] = 8'd255;
        trig_level = 8'd77;
        full_row[227] = 1'b1; full_row[278] = 1'b1;
        scan_frame();

        // Reset mid-DRAW aborts the frame
        clear_rows();
        step(0, 0, 1'b0, 1'b1);
        scan_rows(99, 140);
        do_reset();
        chk_grid = 1'b0;
        for (int x = 300; x <= 303; x++) step(x, 355, 1'b1, 1'b0);
        step(599, 355, 1'b1, 1'b0);
        step(0, 0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0);
        chk_grid = 1'b1;

        // frame_start mid-DRAW restarts; only the restarted frame reaches OVER
        step(0, 0, 1'b0, 1'b1);
        scan_rows(99, 200);
        full_row[227] = 1'b1; full_row[355] = 1'b1;
        scan_frame();
        step(0, 0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
